// File: rtl/shift_sequencer.sv
// Command sequencer feeding a 4-op shifter (hold/asr/shl/load).
// Issues one LOAD followed by N shift cycles per accepted command, tracks
// the expected shifter contents in a shadow register and pulses done at the end.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_amount,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       sel_out,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_ASR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t                  state;
  logic                    dir_q;
  logic [CNT_W-1:0]        amt_q;
  logic [CNT_W-1:0]        count;
  logic signed [WIDTH-1:0] shadow;

  // Sign-preserving one-bit right shift.
  function automatic logic signed [WIDTH-1:0] asr_step(input logic signed [WIDTH-1:0] x);
    return x >>> 1;
  endfunction

  // One-bit left shift, zero filled.
  function automatic logic signed [WIDTH-1:0] shl_step(input logic signed [WIDTH-1:0] x);
    return x << 1;
  endfunction

  // Ready is decoded from state so it drops the moment reset is asserted.
  assign cmd_ready = (state == IDLE) && !reset;
  assign result    = shadow;

  // FSM with registered outputs: each output is loaded with its value for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dir_q    <= 1'b0;
      amt_q    <= '0;
      count    <= '0;
      shadow   <= '0;
      sel_out  <= SEL_HOLD;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sel_out <= SEL_HOLD;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (cmd_valid) begin
            dir_q    <= cmd_dir;
            amt_q    <= cmd_amount;
            data_out <= cmd_data;
            sel_out  <= SEL_LOAD;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          shadow <= data_out;
          count  <= amt_q;
          if (amt_q != '0) begin
            sel_out <= dir_q ? SEL_SHL : SEL_ASR;
            state   <= SHIFT;
          end else begin
            sel_out <= SEL_HOLD;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        SHIFT: begin
          shadow <= dir_q ? shl_step(shadow) : asr_step(shadow);
          count  <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            sel_out <= SEL_HOLD;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a reference 4-bit shifter driven by sel_out/data_out.
module tb_shift_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_amount;
  logic [WIDTH-1:0] cmd_data;
  logic [1:0]       sel_out;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] shifter;
  int               passed;
  int               total;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_amount (cmd_amount),
    .cmd_data   (cmd_data),
    .sel_out    (sel_out),
    .data_out   (data_out),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shifter consuming the sequencer's select/data stream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) shifter <= '0;
    else begin
      case (sel_out)
        2'b01:   shifter <= {shifter[WIDTH-1], shifter[WIDTH-1:1]};
        2'b10:   shifter <= {shifter[WIDTH-2:0], 1'b0};
        2'b11:   shifter <= data_out;
        default: shifter <= shifter;
      endcase
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Issue one command from a negedge in IDLE and check every cycle through the trailing IDLE.
  task automatic run_cmd(input string name, input logic dir, input int n,
                         input logic [WIDTH-1:0] data, input logic [WIDTH-1:0] exp_res);
    logic [1:0] shift_sel;
    shift_sel = dir ? 2'b10 : 2'b01;
    check({name, "_ready_idle"}, 8'(cmd_ready), 8'd1);
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_amount = CNT_W'(n);
    cmd_data   = data;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int j = 1; j <= n + 2; j++) begin
      @(negedge clk);
      check({name, "_ready_busy"}, 8'(cmd_ready), 8'd0);
      check({name, "_busy"}, 8'(busy), 8'd1);
      if (j == 1) begin
        check({name, "_sel_load"}, 8'(sel_out), 8'b11);
        check({name, "_data_out"}, 8'(data_out), 8'(data));
        check({name, "_done_load"}, 8'(done), 8'd0);
      end else if (j <= n + 1) begin
        check({name, "_sel_shift"}, 8'(sel_out), 8'(shift_sel));
        check({name, "_done_shift"}, 8'(done), 8'd0);
      end else begin
        check({name, "_sel_done"}, 8'(sel_out), 8'b00);
        check({name, "_done"}, 8'(done), 8'd1);
        check({name, "_result"}, 8'(result), 8'(exp_res));
        check({name, "_model"}, 8'(shifter), 8'(result));
      end
    end
    @(negedge clk);
    check({name, "_idle_done"}, 8'(done), 8'd0);
    check({name, "_idle_busy"}, 8'(busy), 8'd0);
    check({name, "_idle_sel"}, 8'(sel_out), 8'b00);
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_dir    = 1'b0;
    cmd_amount = '0;
    cmd_data   = '0;

    // Reset state
    #1;
    check("rst_ready", 8'(cmd_ready), 8'd0);
    check("rst_sel", 8'(sel_out), 8'd0);
    check("rst_data_out", 8'(data_out), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    check("rst_result", 8'(result), 8'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 8'(cmd_ready), 8'd1);

    // Directed commands
    run_cmd("t1_asr2", 1'b0, 2, 4'b1011, 4'b1110);
    run_cmd("t2_shl3", 1'b1, 3, 4'b0111, 4'b1000);
    run_cmd("t3_asr7", 1'b0, 7, 4'b1000, 4'b1111);
    run_cmd("t4_n0",   1'b0, 0, 4'b0101, 4'b0101);
    run_cmd("t4b_shl7", 1'b1, 7, 4'b1111, 4'b0000);

    // Back-to-back commands with cmd_valid held high
    cmd_valid  = 1'b1;
    cmd_dir    = 1'b0;
    cmd_amount = 3'd1;
    cmd_data   = 4'b1100;
    @(posedge clk);
    #1;
    cmd_dir    = 1'b1;
    cmd_amount = 3'd2;
    cmd_data   = 4'b0011;
    @(negedge clk);
    check("q_a_sel_load", 8'(sel_out), 8'b11);
    check("q_a_data", 8'(data_out), 8'b1100);
    check("q_a_ready_load", 8'(cmd_ready), 8'd0);
    @(negedge clk);
    check("q_a_sel_shift", 8'(sel_out), 8'b01);
    check("q_a_ready_shift", 8'(cmd_ready), 8'd0);
    @(negedge clk);
    check("q_a_done", 8'(done), 8'd1);
    check("q_a_ready_done", 8'(cmd_ready), 8'd0);
    check("q_a_result", 8'(result), 8'b1110);
    check("q_a_model", 8'(shifter), 8'(result));
    @(negedge clk);
    check("q_idle_ready", 8'(cmd_ready), 8'd1);
    check("q_idle_sel", 8'(sel_out), 8'b00);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("q_b_sel_load", 8'(sel_out), 8'b11);
    check("q_b_data", 8'(data_out), 8'b0011);
    @(negedge clk);
    check("q_b_sel_shift1", 8'(sel_out), 8'b10);
    @(negedge clk);
    check("q_b_sel_shift2", 8'(sel_out), 8'b10);
    @(negedge clk);
    check("q_b_done", 8'(done), 8'd1);
    check("q_b_result", 8'(result), 8'b1100);
    check("q_b_model", 8'(shifter), 8'(result));
    @(negedge clk);
    check("q_no_dup_ready", 8'(cmd_ready), 8'd1);
    @(negedge clk);
    check("q_no_dup_sel", 8'(sel_out), 8'b00);
    check("q_no_dup_busy", 8'(busy), 8'd0);

    // Reset during the second shift cycle of an N=5 command
    cmd_valid  = 1'b1;
    cmd_dir    = 1'b0;
    cmd_amount = 3'd5;
    cmd_data   = 4'b1010;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("ab_sel_load", 8'(sel_out), 8'b11);
    @(negedge clk);
    check("ab_sel_shift1", 8'(sel_out), 8'b01);
    @(negedge clk);
    check("ab_sel_shift2", 8'(sel_out), 8'b01);
    reset = 1'b1;
    #1;
    check("ab_rst_sel", 8'(sel_out), 8'd0);
    check("ab_rst_data_out", 8'(data_out), 8'd0);
    check("ab_rst_busy", 8'(busy), 8'd0);
    check("ab_rst_done", 8'(done), 8'd0);
    check("ab_rst_result", 8'(result), 8'd0);
    check("ab_rst_ready", 8'(cmd_ready), 8'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("ab_no_done", 8'(done), 8'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("ab_post_no_done", 8'(done), 8'd0);
      check("ab_post_ready", 8'(cmd_ready), 8'd1);
    end
    run_cmd("t6_after", 1'b1, 1, 4'b0101, 4'b1010);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
